// File: rtl/ram_capture_pkg.sv
// Shared types and default widths for the capture ring-buffer controller.
package ram_capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DUMP  = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/ram_capture_rd_pipe.sv
// Readout side of the capture buffer: issues one RAM read per free output slot
// and tracks the registered-read valid flag so the sink sees 1 sample/cycle.
module ram_capture_rd_pipe
    import ram_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  load,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] load_ptr,
    input  logic                  out_ready,
    output logic                  rd_issue,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  out_valid,
    output logic                  last_hs
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   rd_left;

    // A read may be issued whenever the single output slot is empty or draining.
    assign rd_issue = active & (rd_left != '0) & (~out_valid | out_ready);
    assign rd_addr  = rd_ptr;
    assign last_hs  = active & out_valid & out_ready & (rd_left == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            rd_left   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            rd_left   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            rd_ptr    <= load_ptr;
            rd_left   <= DEPTH_W;
            out_valid <= 1'b0;
        end else if (rd_issue) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            rd_left   <= rd_left - CNT_ONE;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_capture_ctrl.sv
// Pre/post-trigger capture ring buffer sequencer driving a synchronous sample RAM.
// Optional dropped-sample counter enabled by RAM_CAPTURE_CTRL_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting for start, samples dropped
// PRE   | filling the pre-trigger portion, trig ignored
// ARMED | circular writing, waiting for trig
// POST  | collecting the post-trigger portion
// DUMP  | streaming the frozen window out oldest-first
module ram_capture_ctrl
    import ram_capture_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_cnt,
    input  logic                  trig,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
`ifdef RAM_CAPTURE_CTRL_OVERRUN_EN
    ,
    output logic [15:0]           overrun_cnt
`endif
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] start_ptr;
    logic [ADDR_WIDTH:0]   post_left;

    logic                  wr_phase;
    logic                  in_dump;
    logic                  rd_issue;
    logic                  rd_last;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] start_now;
    logic [ADDR_WIDTH-1:0] load_ptr;
    logic [ADDR_WIDTH:0]   post_init;
    logic [ADDR_WIDTH:0]   post_dec;

    assign wr_phase   = (state == PRE) | (state == ARMED) | (state == POST);
    assign in_dump    = (state == DUMP);
    assign ram_we     = in_valid & wr_phase;
    assign ram_en     = ram_we | rd_issue;
    assign ram_w_addr = wr_ptr;
    assign ram_di     = in_data;
    assign out_data   = ram_dout;
    assign busy       = (state != IDLE);

    assign start_now = wr_ptr - pre_q;
    assign post_init = DEPTH_W - {1'b0, pre_q};
    assign post_dec  = {{ADDR_WIDTH{1'b0}}, in_valid};

    // The trig-cycle sample counts as post data, so a window with one post slot
    // can go straight from ARMED to DUMP.
    assign rd_load  = ~abort & (((state == ARMED) & trig & in_valid & (post_init == CNT_ONE)) |
                                ((state == POST) & in_valid & (post_left == CNT_ONE)));
    assign load_ptr = (state == ARMED) ? start_now : start_ptr;

    ram_capture_rd_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .active    (in_dump),
        .load      (rd_load),
        .clear     (abort),
        .load_ptr  (load_ptr),
        .out_ready (out_ready),
        .rd_issue  (rd_issue),
        .rd_addr   (ram_r_addr),
        .out_valid (out_valid),
        .last_hs   (rd_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            pre_q     <= '0;
            start_ptr <= '0;
            post_left <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ram_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            wr_ptr <= '0;
                            fill   <= '0;
                            pre_q  <= pre_cnt;
                            state  <= (pre_cnt == '0) ? ARMED : PRE;
                        end
                    end
                    PRE: begin
                        if (in_valid) begin
                            fill <= fill + PTR_ONE;
                            if (fill + PTR_ONE == pre_q) begin
                                state <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (trig) begin
                            start_ptr <= start_now;
                            post_left <= post_init - post_dec;
                            state     <= rd_load ? DUMP : POST;
                        end
                    end
                    POST: begin
                        if (in_valid) begin
                            post_left <= post_left - CNT_ONE;
                            if (post_left == CNT_ONE) begin
                                state <= DUMP;
                            end
                        end
                    end
                    DUMP: begin
                        if (rd_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RAM_CAPTURE_CTRL_OVERRUN_EN
    logic drop;
    assign drop = in_valid & ((state == IDLE) | (state == DUMP));

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (!abort && (state == IDLE) && start) begin
            overrun_cnt <= '0;
        end else if (drop && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule
